// File: rtl/fifo_pkg.sv
// Shared definitions for the common buffering library: default sizes, the
// clog2 helper and a status bundle for wrappers that export FIFO state.
package fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 256;
  localparam int STATUS_CNT_W = 32;

  typedef struct packed {
    logic [STATUS_CNT_W-1:0] usedw;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
  } fifo_status_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. Contents are never reset, so a vendor RAM can be dropped in here.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sc_show_ahead.sv
// Single-clock show-ahead FIFO: registered head word on q, full-range
// occupancy count, programmable almost flags and overflow/underflow pulses.
module fifo_sc_show_ahead
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                    clock,
  input  logic                    aclr_n,
  input  logic                    sclr,
  input  logic [DATA_W-1:0]       data,
  input  logic                    wrreq,
  input  logic                    rdreq,
  output logic [DATA_W-1:0]       q,
  output logic [clog2(DEPTH):0]   usedw,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW    = clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_next;
  logic [CNT_W-1:0]  usedw_nxt;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_acc;
  logic              rd_acc;
  logic              bypass;

  // Handshake: wrreq/rdreq are single-cycle requests sampled on the rising
  // edge. A write is taken when !full, or when full and paired with a read;
  // rdreq acknowledges the word on q and is taken only when !empty.
  assign wr_acc      = wrreq & (~full | rdreq);
  assign rd_acc      = rdreq & ~empty;
  assign rd_ptr_next = rd_ptr + PTR_ONE;

  // New data goes straight to q when it becomes the head word this edge.
  assign bypass = wr_acc & (empty | ((usedw == CNT_ONE) & rd_acc));

  always_comb begin
    usedw_nxt = usedw;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_nxt = usedw + CNT_ONE;
      2'b01:   usedw_nxt = usedw - CNT_ONE;
      default: usedw_nxt = usedw;
    endcase
  end

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clock),
    .we    (wr_acc & ~sclr),
    .waddr (wr_ptr),
    .wdata (data),
    .raddr (rd_ptr_next),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      q            <= '0;
    end else if (sclr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      q            <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr_next;
      usedw        <= usedw_nxt;
      full         <= (usedw_nxt == CNT_FULL);
      empty        <= (usedw_nxt == '0);
      almost_full  <= (usedw_nxt >= CNT_AF);
      almost_empty <= (usedw_nxt <= CNT_AE);
      overflow     <= wrreq & full & ~rdreq;
      underflow    <= rdreq & empty;
      // After a lone read that empties the FIFO, q takes a stale word; it is
      // don't-care while empty.
      if (bypass)      q <= data;
      else if (rd_acc) q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_fifo_sc_show_ahead.sv
// Bench for fifo_sc_show_ahead: directed scenarios plus a random phase, all
// checked against a queue-based model of FIFO behaviour.
module tb_fifo_sc_show_ahead;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 4;
  localparam int AE     = 2;

  logic              clock;
  logic              aclr_n;
  logic              sclr;
  logic [DATA_W-1:0] data;
  logic              wrreq;
  logic              rdreq;
  logic [DATA_W-1:0] q;
  logic [3:0]        usedw;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  int errors = 0;
  int checks = 0;

  // Scoreboard: model contents, expected head word and pulse flags.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] q_exp;
  logic              q_known;
  logic              ov_exp;
  logic              un_exp;

  fifo_sc_show_ahead #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clock        (clock),
    .aclr_n       (aclr_n),
    .sclr         (sclr),
    .data         (data),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .q            (q),
    .usedw        (usedw),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    check("usedw", 32'(usedw), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow", 32'(overflow), 32'(ov_exp));
    check("underflow", 32'(underflow), 32'(un_exp));
    if (q_known) check("q", 32'(q), 32'(q_exp));
  endtask

  task automatic model_clear();
    exp_q.delete();
    q_exp   = '0;
    q_known = 1'b1;
    ov_exp  = 1'b0;
    un_exp  = 1'b0;
  endtask

  // Driver: called at a falling edge, applies one cycle of inputs.
  task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d, input logic sc);
    int  n;
    logic wacc, racc;
    wrreq = wr;
    rdreq = rd;
    data  = d;
    sclr  = sc;
    @(posedge clock);
    #1;
    n = exp_q.size();
    if (sc) begin
      model_clear();
    end else begin
      ov_exp = wr && (n == DEPTH) && !rd;
      un_exp = rd && (n == 0);
      racc   = rd && (n > 0);
      wacc   = wr && ((n < DEPTH) || rd);
      if (racc) void'(exp_q.pop_front());
      if (wacc) exp_q.push_back(d);
      if (exp_q.size() > 0) begin
        q_exp   = exp_q[0];
        q_known = 1'b1;
      end else if (racc) begin
        q_known = 1'b0;
      end
    end
    check_all();
    @(negedge clock);
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] cnt;
    aclr_n = 1'b0;
    sclr   = 1'b0;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    data   = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    aclr_n = 1'b1;

    // Single word in, single word out
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    check("first_word_q", 32'(q), 32'h0000_00A5);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Fill to full, then an overflowing write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("q_after_overflow", 32'(q), 32'h0);

    // Simultaneous read/write while full, then drain
    step(1'b1, 1'b1, 8'h55, 1'b0);
    check("usedw_full_rw", 32'(usedw), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Read of an empty FIFO paired with a write
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    check("q_underflow_write", 32'(q), 32'h3C);

    // Streaming at constant occupancy with pointer wrap
    cnt = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, cnt, 1'b0);
      cnt++;
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, 1'b1, cnt, 1'b0);
      cnt++;
    end

    // Synchronous clear from half full
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    check("q_after_sclr", 32'(q), 32'h0);

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 2));
    end

    // Asynchronous reset mid-burst, checked before any clock edge
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom_range(1, 255)), 1'b0);
    wrreq = 1'b1;
    data  = 8'h77;
    #2;
    aclr_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clock);
    wrreq  = 1'b0;
    aclr_n = 1'b1;
    step(1'b1, 1'b0, 8'h42, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sc_show_ahead.md
# fifo_sc_show_ahead

Parametrised single-clock show-ahead (first-word-fall-through) FIFO that succeeds the fixed 8-bit/256-word CDC-area buffers. It adds:
- configurable width and depth;
- a full-range occupancy count;
- programmable almost-full/almost-empty flags;
- synchronous clear;
- overflow/underflow error pulses.

It sits between request/response pipelines in the common buffering library and is instantiated wherever a same-clock elastic buffer with head-of-queue visibility is needed.

## Interface
Parameters:
- DATA_W, 8, word width in bits (≥1)
- DEPTH, 256, number of words; power of two, ≥4
- AF_LEVEL, DEPTH-4, almost_full asserts when usedw ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when usedw ≤ AE_LEVEL (0..DEPTH-1)

Ports (CNT_W = log2(DEPTH)+1):
- clock  in  1  single clock; all logic on rising edge
- aclr_n  in  1  asynchronous active-low reset
- sclr  in  1  synchronous clear, active-high; same effect as reset on the next edge
- data  in  DATA_W  write data
- wrreq  in  1  write request
- rdreq  in  1  read/acknowledge of the current head word
- q  out  DATA_W  head-of-queue word; valid whenever empty=0
- usedw  out  CNT_W  occupancy, 0..DEPTH inclusive (never wraps)
- full  out  1  usedw == DEPTH
- empty  out  1  usedw == 0
- almost_full  out  1  usedw ≥ AF_LEVEL
- almost_empty  out  1  usedw ≤ AE_LEVEL
- overflow  out  1  one-cycle pulse: rejected write
- underflow  out  1  one-cycle pulse: rejected read

## Operation
- Reset (aclr_n=0, asynchronous) or sclr=1 (synchronous):
  - pointers and usedw are set to 0;
  - empty=1, almost_empty=1;
  - full=0, almost_full=0 (almost_full is 0 even when AF_LEVEL would otherwise match 0);
  - overflow=0, underflow=0, q=0.
  - Storage array is not reset.
  - sclr takes priority over wrreq/rdreq in the same cycle.
- Write accepted = wrreq & (!full | rdreq). Data goes to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- Read accepted = rdreq & !empty. rd_ptr increments modulo DEPTH.
- wrreq & full & !rdreq:
  - write dropped, contents unchanged;
  - overflow=1 for one cycle.
- rdreq & empty:
  - read ignored; underflow=1 for one cycle;
  - a simultaneous wrreq is still accepted.
- Full with wrreq & rdreq: both accepted, usedw stays DEPTH, no overflow.
- usedw changes by +1 (write only), -1 (read only) or 0 (both or neither).
- Show-ahead: q always presents mem[rd_ptr] through a registered output stage. Next-q selection:
  - write into empty FIFO, or write while usedw==1 and a read is accepted → data bypassed directly;
  - otherwise, after an accepted read → mem[rd_ptr+1];
  - otherwise q holds.
- When empty, q holds its last value; it is don't-care to consumers.
- Pointers are log2(DEPTH) bits with natural wrap; full/empty are decoded from the registered usedw, not pointer comparison.

## Timing
- All outputs are registered; none is combinational from inputs.
- Write at edge N into an empty FIFO: empty=0, usedw=1 and q=data are all valid in the cycle after edge N. First-word latency is 1 cycle.
- Accepted read at edge N: the next word is on q in the cycle after edge N. Back-to-back reads at one word per cycle are sustained.
- Throughput: one write and one read per cycle with no bubbles at any occupancy.
- full, empty, almost_full, almost_empty, usedw update on the same edge as the accepted operation.
- overflow/underflow are asserted in the cycle after the offending edge, for exactly one cycle per offending request.
- aclr_n deassertion is expected to be synchronised externally. The first operation is honoured on the first edge with aclr_n=1.

## Structure
- Shared package fifo_pkg:
  - function clog2 helper;
  - localparam-style constants for default DATA_W/DEPTH;
  - a fifo_status_t struct bundling usedw, full, empty, almost_full, almost_empty, used by any wrapper that exports status.
- One sub-module, fifo_sdp_ram:
  - simple dual-port array, one write port and one asynchronous read port;
  - parametrised DATA_W/DEPTH;
  - a vendor RAM can be substituted later.
- Top level holds the pointers, usedw counter, flag registers, q register and bypass mux.

## Test plan
- Reset then write 0xA5 once (DATA_W=8, DEPTH=8) → next cycle empty=0, usedw=1, q=0xA5; rdreq one cycle → empty=1, usedw=0.
- Write 0x00..0x07 into DEPTH=8 → full=1, usedw=8, almost_full=1 at usedw≥4 (AF_LEVEL=4); 9th write 0xFF → overflow pulse, q still 0x00.
- Full FIFO, wrreq+rdreq with data 0x55 → usedw stays 8, no overflow; draining yields 0x01..0x07 then 0x55 in order.
- Empty FIFO, rdreq+wrreq with 0x3C → underflow pulse, usedw=1, q=0x3C next cycle.
- Continuous simultaneous read/write for 3×DEPTH cycles with an incrementing pattern → pointers wrap, output sequence is gap-free and in order, and usedw stays constant.
- Half-full (usedw=4): assert sclr → next cycle usedw=0, empty=1. Separately, drop aclr_n mid-burst → all flags and q return to reset values immediately, without waiting for a clock edge.
